// File: rtl/tx_mod_pkg.sv
// Shared definitions for the Tx modulation chain: standard symbol orders,
// the order-field width helper and the default symbol FIFO entry layout.
package tx_mod_pkg;

    localparam int ORD_BPSK  = 1;
    localparam int ORD_QPSK  = 2;
    localparam int ORD_QAM16 = 4;
    localparam int ORD_QAM64 = 6;

    // Bits needed to hold an order value in the range 0..max_bits.
    function automatic int mo_w(input int max_bits);
        return $clog2(max_bits + 1);
    endfunction

    localparam int ENTRY_MAX_BITS = 6;

    // FIFO entry for the default 6-bit configuration; the packer stores the same
    // {order, word} layout as a flat vector so that it scales with MAX_BITS.
    typedef struct packed {
        logic [mo_w(ENTRY_MAX_BITS)-1:0] order;
        logic [ENTRY_MAX_BITS-1:0]       word;
    } sym_entry_t;

endpackage

// File: rtl/sym_fifo.sv
// Show-ahead synchronous FIFO holding completed symbols; the head entry is
// visible combinationally whenever the FIFO is not empty.
module sym_fifo #(
    parameter  int WIDTH  = 9,
    parameter  int DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int FW     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [FW-1:0]    fill
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == FW'(DEPTH));
    assign empty   = (count_q == '0);
    assign fill    = count_q;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + FW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - FW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; emptiness alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/symbol_packer.sv
// Serial-to-symbol packer: gathers accepted bits into symbols of a per-symbol
// latched order and queues {order, word} entries for the mapper.
module symbol_packer
    import tx_mod_pkg::*;
#(
    parameter  int MAX_BITS   = 6,
    parameter  int FIFO_DEPTH = 4,
    parameter  bit MSB_FIRST  = 1'b1,
    localparam int MO_W       = mo_w(MAX_BITS),
    localparam int FILL_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ibit,
    input  logic                ival,
    output logic                oreq,
    input  logic [MO_W-1:0]     modOrder,
    input  logic                ireq,
    output logic                oval,
    output logic [MAX_BITS-1:0] obit,
    output logic [MO_W-1:0]     onbits,
    input  logic                flush,
    output logic                err_mode,
    output logic [FILL_W-1:0]   fill
);

    localparam int ENTRY_W = MO_W + MAX_BITS;

    logic [MO_W-1:0]     cnt_q, cnt_d;
    logic [MO_W-1:0]     cur_order_q, cur_order_d;
    logic [MAX_BITS-1:0] sr_q, sr_d;
    logic                err_q, err_d;

    logic [MO_W-1:0]     order_eff;
    logic [MAX_BITS-1:0] sr_base, word_next;
    logic                legal_in, mid_sym, accept, complete;
    logic                fifo_full, fifo_empty, fifo_pop;
    logic [ENTRY_W-1:0]  push_data, head;

    assign mid_sym   = (cnt_q != '0);
    assign legal_in  = (modOrder != '0) && (modOrder <= MO_W'(MAX_BITS));
    assign order_eff = mid_sym ? cur_order_q : modOrder;

    assign oreq      = ~fifo_full & (legal_in | mid_sym) & ~flush & ~rst;
    assign accept    = ival & oreq;
    assign complete  = accept && (cnt_q == order_eff - MO_W'(1));

    // A new symbol always starts from an all-zero word so unused high bits stay 0.
    assign sr_base   = mid_sym ? sr_q : '0;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign word_next = {sr_base[MAX_BITS-2:0], ibit};
        end else begin : g_lsb_first
            for (genvar gi = 0; gi < MAX_BITS; gi++) begin : g_bit
                assign word_next[gi] = sr_base[gi] | (ibit & (cnt_q == MO_W'(gi)));
            end
        end
    endgenerate

    assign push_data = {order_eff, word_next};

    always_comb begin
        cnt_d       = cnt_q;
        cur_order_d = cur_order_q;
        sr_d        = sr_q;
        err_d       = err_q;
        if (!mid_sym && !legal_in) begin
            err_d = 1'b1;
        end
        if (accept && !mid_sym) begin
            cur_order_d = modOrder;
        end
        if (flush || complete) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (accept) begin
            cnt_d = cnt_q + MO_W'(1);
            sr_d  = word_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            cur_order_q <= '0;
            sr_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            cur_order_q <= cur_order_d;
            sr_q        <= sr_d;
            err_q       <= err_d;
        end
    end

    assign err_mode = err_q;
    assign oval     = ~fifo_empty;
    assign fifo_pop = oval & ireq;
    assign obit     = oval ? head[MAX_BITS-1:0] : '0;
    assign onbits   = oval ? head[ENTRY_W-1:MAX_BITS] : '0;

    sym_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (complete),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .fill      (fill)
    );

endmodule

// File: tb/tb_symbol_packer.sv
// Scoreboard bench for symbol_packer: one MSB-first and one LSB-first instance
// share the stimulus; a bit-level model queues the expected symbols.
module tb_symbol_packer;
    import tx_mod_pkg::*;

    localparam int MB  = 6;
    localparam int FD  = 4;
    localparam int MOW = mo_w(MB);
    localparam int FW  = $clog2(FD + 1);

    logic           clk = 1'b0;
    logic           rst, ibit, ival, ireq, flush;
    logic [MOW-1:0] modOrder;

    logic           m_oreq, m_oval, m_err;
    logic [MB-1:0]  m_obit;
    logic [MOW-1:0] m_onbits;
    logic [FW-1:0]  m_fill;
    logic           l_oreq, l_oval, l_err;
    logic [MB-1:0]  l_obit;
    logic [MOW-1:0] l_onbits;
    logic [FW-1:0]  l_fill;

    int checks = 0;
    int errors = 0;
    int q_msb[$];
    int q_lsb[$];
    int mcnt, morder, mw_msb, mw_lsb;

    always #5 clk = ~clk;

    symbol_packer #(.MAX_BITS(MB), .FIFO_DEPTH(FD), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .ibit(ibit), .ival(ival), .oreq(m_oreq),
        .modOrder(modOrder), .ireq(ireq), .oval(m_oval), .obit(m_obit),
        .onbits(m_onbits), .flush(flush), .err_mode(m_err), .fill(m_fill)
    );

    symbol_packer #(.MAX_BITS(MB), .FIFO_DEPTH(FD), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .ibit(ibit), .ival(ival), .oreq(l_oreq),
        .modOrder(modOrder), .ireq(ireq), .oval(l_oval), .obit(l_obit),
        .onbits(l_onbits), .flush(flush), .err_mode(l_err), .fill(l_fill)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mcnt   = 0;
        morder = 0;
        mw_msb = 0;
        mw_lsb = 0;
    endtask

    task automatic model_accept(input logic b);
        if (mcnt == 0) morder = int'(modOrder);
        mw_msb = (mw_msb << 1) | int'(b);
        mw_lsb = mw_lsb | (int'(b) << mcnt);
        mcnt++;
        if (mcnt == morder) begin
            q_msb.push_back(morder * 256 + mw_msb);
            q_lsb.push_back(morder * 256 + mw_lsb);
            model_reset();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that took the bit.
    task automatic send_bit(input logic b);
        bit done;
        done = 1'b0;
        ibit = b;
        ival = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (m_oreq) done = 1'b1;
            tick();
        end
        ival = 1'b0;
        if (!done) chk("oreq_timeout", 0, 1);
        else model_accept(b);
    endtask

    task automatic drain();
        ireq = 1'b1;
        for (int i = 0; i < 60 && (q_msb.size() + q_lsb.size()) != 0; i++) tick();
        chk("drain_sb_empty", q_msb.size() + q_lsb.size(), 0);
    endtask

    always @(negedge clk) begin
        int e;
        if (!rst && ireq) begin
            if (m_oval) begin
                if (q_msb.size() == 0) chk("msb_unexpected_sym", int'(m_obit), -1);
                else begin
                    e = q_msb.pop_front();
                    chk("msb_sym", int'(m_onbits) * 256 + int'(m_obit), e);
                    $display("msb symbol order=%0d word=%0d", m_onbits, m_obit);
                end
            end
            if (l_oval) begin
                if (q_lsb.size() == 0) chk("lsb_unexpected_sym", int'(l_obit), -1);
                else begin
                    e = q_lsb.pop_front();
                    chk("lsb_sym", int'(l_onbits) * 256 + int'(l_obit), e);
                    $display("lsb symbol order=%0d word=%0d", l_onbits, l_obit);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ival = 1'b0; ibit = 1'b0; ireq = 1'b0; flush = 1'b0;
        modOrder = MOW'(ORD_QPSK);
        model_reset();
        #1;
        tick();
        tick();
        chk("rst_oval", int'(m_oval), 0);
        chk("rst_fill", int'(m_fill), 0);
        chk("rst_oreq", int'(m_oreq), 0);
        chk("rst_obit", int'(m_obit), 0);
        chk("rst_err", int'(m_err), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("oreq_after_rst", int'(m_oreq), 1);
        tick();

        // QPSK, latency of the first symbol
        ireq = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        chk("qpsk_lat_oval", int'(m_oval), 1);
        chk("qpsk_msb_word", int'(m_obit), 2);
        chk("qpsk_lsb_word", int'(l_obit), 1);
        chk("qpsk_onbits", int'(m_onbits), 2);
        send_bit(1'b1);
        send_bit(1'b1);
        drain();

        // QAM64, bit order
        modOrder = MOW'(ORD_QAM64);
        send_bit(1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        chk("qam64_msb_word", int'(m_obit), 32);
        chk("qam64_lsb_word", int'(l_obit), 1);
        drain();

        // Order switch mid-symbol
        modOrder = MOW'(ORD_QAM16);
        send_bit(1'b1);
        send_bit(1'b0);
        modOrder = MOW'(ORD_QPSK);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("switch_onbits", int'(m_onbits), 4);
        chk("switch_msb_word", int'(m_obit), 11);
        chk("switch_lsb_word", int'(l_obit), 13);
        send_bit(1'b0);
        send_bit(1'b1);
        drain();

        // Backpressure with order 1
        ireq = 1'b0;
        modOrder = MOW'(ORD_BPSK);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("bp_fill_full", int'(m_fill), 4);
        chk("bp_fill_full_lsb", int'(l_fill), 4);
        @(negedge clk);
        chk("bp_oreq_low", int'(m_oreq), 0);
        tick();
        ibit = 1'b0;
        ival = 1'b1;
        tick();
        chk("bp_hold_fill", int'(m_fill), 4);
        ival = 1'b0;
        ireq = 1'b1;
        tick();
        ireq = 1'b0;
        chk("bp_one_pop", int'(m_fill), 3);
        @(negedge clk);
        chk("bp_oreq_back", int'(m_oreq), 1);
        tick();
        send_bit(1'b0);
        chk("bp_refill", int'(m_fill), 4);
        drain();

        // Illegal order
        modOrder = MOW'(7);
        ibit = 1'b1;
        ival = 1'b1;
        tick();
        @(negedge clk);
        chk("illegal_oreq", int'(m_oreq), 0);
        chk("illegal_err", int'(m_err), 1);
        tick();
        ival = 1'b0;
        modOrder = MOW'(ORD_QPSK);
        tick();
        @(negedge clk);
        chk("err_sticky", int'(m_err), 1);
        chk("legal_oreq", int'(m_oreq), 1);
        tick();
        send_bit(1'b0);
        send_bit(1'b1);
        drain();

        // Flush of a partial symbol
        modOrder = MOW'(ORD_QAM16);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        flush = 1'b1;
        ibit = 1'b1;
        ival = 1'b1;
        @(negedge clk);
        chk("flush_oreq", int'(m_oreq), 0);
        tick();
        flush = 1'b0;
        ival = 1'b0;
        model_reset();
        chk("flush_no_push", int'(m_fill), 0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        drain();

        // Async reset mid-symbol
        ireq = 1'b0;
        modOrder = MOW'(ORD_QPSK);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_fill", int'(m_fill), 0);
        chk("arst_oval", int'(m_oval), 0);
        chk("arst_obit", int'(m_obit), 0);
        chk("arst_onbits", int'(m_onbits), 0);
        chk("arst_oreq", int'(m_oreq), 0);
        chk("arst_err", int'(m_err), 0);
        q_msb.delete();
        q_lsb.delete();
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        ireq = 1'b1;
        send_bit(1'b0);
        send_bit(1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/symbol_packer.md
# symbol_packer

Parametrised serial-to-symbol packer for the Tx chain: collects a 1-bit stream into symbol words of `modOrder` bits (any value 1..MAX_BITS, not only 1/2/4/6) and presents them to the mapper through a small show-ahead symbol FIFO. It replaces the fixed 6-bit converter. New behaviour over the previous generation:

- modulation order is locked per symbol;
- bit order is selectable;
- output decouples from the mapper via a FIFO with full backpressure;
- partial symbols can be flushed;
- illegal orders are flagged.

## Interface
- `MAX_BITS`, 6, widest symbol in bits (≥2)
- `FIFO_DEPTH`, 4, symbol FIFO entries (power of two, ≥2)
- `MSB_FIRST`, 1, 1: first received bit is the symbol MSB; 0: first bit is LSB
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `ibit`  in  1  serial data bit
- `ival`  in  1  `ibit` valid
- `oreq`  out  1  block accepts a bit this cycle; a bit transfers when `ival & oreq`
- `modOrder`  in  MO_W = $clog2(MAX_BITS+1)  bits per symbol, sampled at symbol start
- `ireq`  in  1  mapper ready; a symbol transfers when `oval & ireq`
- `oval`  out  1  FIFO head valid
- `obit`  out  MAX_BITS  symbol, right-aligned; bits ≥ order are 0
- `onbits`  out  MO_W  order of the head symbol
- `flush`  in  1  discard the partial symbol
- `err_mode`  out  1  sticky: illegal `modOrder` seen at symbol start
- `fill`  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy

## Operation
- **Packer state:** bit counter `cnt` (0..MAX_BITS-1), latched order `cur_order`, shift register `sr`.
- **First accepted bit of a symbol (`cnt==0`):**
  - `cur_order` ← `modOrder`.
  - `modOrder` changes while `cnt≠0` are ignored until the next symbol.
- **Illegal order** (`modOrder==0` or `>MAX_BITS`) while `cnt==0`:
  - `oreq`=0, no bit is consumed, `err_mode`←1.
  - `err_mode` clears only on `rst`.
- **Bit placement:**
  - `MSB_FIRST=1`: shift left, the new bit enters at bit 0, so the first bit ends at `obit[cur_order-1]`.
  - `MSB_FIRST=0`: the k-th bit (k from 0) goes to `obit[k]`.
- **Symbol completion:** on the accepted bit with `cnt==cur_order-1`, push {`cur_order`, zero-extended word} into the FIFO and set `cnt`←0. Order 1 completes on every bit.
- **`oreq`** = `~full & legal_order_or_midsymbol & ~flush & ~rst`. A full FIFO stalls bits. Pushing into a full FIFO never happens.
- **FIFO:** show-ahead. `obit`/`onbits` are 0 when `oval`=0. Simultaneous push and pop are allowed whenever the FIFO is not full, and `fill` is unchanged.
- **`flush`:** `cnt`←0 and `sr`←0. FIFO contents are kept. If `flush` coincides with a completing bit, that bit is not accepted (`oreq`=0).
- **Reset (async):**
  - `cnt`=0, `cur_order`=0, `sr`=0, FIFO empty, `err_mode`=0.
  - Outputs: `oval`=0, `obit`=0, `onbits`=0, `fill`=0, `oreq`=0 while `rst` is high.
  - A reset mid-symbol drops the partial symbol.

## Timing
- `oreq` is valid in the first cycle after `rst` deasserts, if `modOrder` is legal.
- Latency: last bit of a symbol accepted at edge N → `oval`=1 with the symbol after edge N (the same cycle the counter returns to 0) when the FIFO was empty.
- Throughput: one bit per cycle sustained while `ireq` keeps the FIFO non-full.
- The mapper may hold `ireq` high continuously. With `ireq` low, the FIFO fills after FIFO_DEPTH symbols, then `oreq` drops in the following cycle.

## Structure
- Package `tx_mod_pkg`:
  - order constants `ORD_BPSK=1`, `ORD_QPSK=2`, `ORD_QAM16=4`, `ORD_QAM64=6`;
  - function `mo_w(max_bits)`;
  - typedef for the FIFO entry struct {order, word}.
- Sub-module `sym_fifo`: synchronous show-ahead FIFO, async reset, `push`/`pop`/`full`/`empty`/`fill`, width MAX_BITS+MO_W. The top level keeps the counter, shift register and order control.

## Test plan
- **QPSK, MSB_FIRST=1, ireq=1:** bits 1,0,1,1 → two symbols, `obit`=6'b000010 then 6'b000011, `onbits`=2. The first symbol is valid 1 cycle after its 2nd bit.
- **QAM64, MSB_FIRST=0:** bits 1,0,0,0,0,0 → `obit`=6'b000001. With MSB_FIRST=1 the same bits → 6'b100000.
- **Order switch mid-symbol:** `modOrder` 4→2 after the 2nd bit → first symbol still 4 bits; the next symbol is 2 bits.
- **Backpressure, FIFO_DEPTH=4, order 1, ireq=0:** 4 bits accepted, `fill`=4, `oreq`=0. Then ireq=1 for 1 cycle → one pop, `oreq` returns 1 the next cycle, and no bit is lost or duplicated.
- **Illegal order:** `modOrder`=7 with MAX_BITS=6 at symbol start → `oreq`=0, `err_mode`=1 and it stays 1 after returning to order 2.
- **Flush / reset:** 3 of 4 bits then `flush` → no symbol pushed and the next 4 bits form a clean symbol. Async `rst` mid-symbol → all outputs 0 immediately, `fill`=0.
